// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - memory access size/sign types, LSU state encoding and alignment helpers
package riscv;

    typedef enum logic [1:0] {
        BYTE  = 2'b00,
        HWORD = 2'b01,
        WORD  = 2'b10
    } mem_size_t;

    typedef enum logic {
        SIGNED   = 1'b0,
        UNSIGNED = 1'b1
    } sign_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        RESP = 2'b11
    } lsu_state_t;

    // Byte lanes touched by an access of the given size at the given word offset.
    function automatic logic [3:0] lsu_be(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            BYTE:    be = 4'b0001 << addr_lo;
            HWORD:   be = 4'b0011 << {addr_lo[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Size 2'b11 is not an encoding the core ever issues, so it is rejected like a misalignment.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            BYTE:    bad = 1'b0;
            HWORD:   bad = addr_lo[0];
            WORD:    bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte enables, store lane replication and load shift/extension
// size/is_unsigned/addr_lo describe the access; st_data/ld_raw are raw register and bus words;
// be/st_lanes go to the bus, ld_data is the extended register value.
module lsu_align
    import riscv::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_raw,
    output logic [3:0]  be,
    output logic [31:0] st_lanes,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        be       = lsu_be(size, addr_lo);
        st_lanes = st_data;
        ld_data  = 32'h0;
        shifted  = ld_raw >> {addr_lo, 3'b000};

        case (size)
            BYTE:  st_lanes = {4{st_data[7:0]}};
            HWORD: st_lanes = {2{st_data[15:0]}};
            default: st_lanes = st_data;
        endcase

        // A word load has no upper bits to fill, so the sign flag is irrelevant there.
        case (size)
            BYTE:    ld_data = is_unsigned ? {24'h0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
            HWORD:   ld_data = is_unsigned ? {16'h0, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store controller: request capture, memory handshake, timeout, writeback
// req_*: decoded access in; mem_*: data-memory request/grant/response port;
// wb_*: one-cycle register writeback; misalign_o/bus_err_o/err_addr_o: error reporting.
module lsu_ctrl
    import riscv::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_is_store_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic [31:0] err_addr_o
);

    // The counter only ever needs to hold 0..TIMEOUT-1 before the access is abandoned.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    lsu_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic        we_q, uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, wb_data_q, err_addr_q;
    logic [4:0]  rd_q;
    logic        misalign_q, bus_err_q;

    logic        accept, bad_req, in_flight, done, timeout;
    logic [3:0]  be;
    logic [31:0] st_lanes, ld_data;

    lsu_align u_align (
        .size        (size_q),
        .is_unsigned (uns_q),
        .addr_lo     (addr_q[1:0]),
        .st_data     (wdata_q),
        .ld_raw      (mem_rdata_i),
        .be          (be),
        .st_lanes    (st_lanes),
        .ld_data     (ld_data)
    );

    assign accept    = req_valid_i && (state_q == IDLE);
    assign bad_req   = lsu_misaligned(req_size_i, req_addr_i[1:0]);
    assign in_flight = (state_q == REQ) || (state_q == WAIT);
    // A grant carrying its response in the same cycle finishes the access outright.
    assign done      = ((state_q == REQ)  && mem_gnt_i && mem_rvalid_i) ||
                       ((state_q == WAIT) && mem_rvalid_i);
    // A completion arriving on the last allowed cycle takes priority over the timeout.
    assign timeout   = in_flight && (cnt_q == CNT_LAST) && !done;

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        mem_req_o   = 1'b0;
        wb_valid_o  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (accept && !bad_req) state_d = REQ;
            end
            REQ: begin
                mem_req_o = 1'b1;
                if (done)           state_d = we_q ? IDLE : RESP;
                else if (timeout)   state_d = IDLE;
                else if (mem_gnt_i) state_d = WAIT;
            end
            WAIT: begin
                if (done)         state_d = we_q ? IDLE : RESP;
                else if (timeout) state_d = IDLE;
            end
            RESP: begin
                // x0 loads still pass through RESP but never write the register file.
                wb_valid_o = (rd_q != 5'd0);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rd_q       <= 5'd0;
            wb_data_q  <= 32'h0;
            err_addr_q <= 32'h0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            misalign_q <= accept && bad_req;
            bus_err_q  <= timeout;

            if (accept && bad_req) err_addr_q <= req_addr_i;
            else if (timeout)      err_addr_q <= addr_q;

            if (accept && !bad_req) begin
                we_q    <= req_is_store_i;
                uns_q   <= req_unsigned_i;
                size_q  <= req_size_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                rd_q    <= req_rd_i;
                cnt_q   <= '0;
            end else if (in_flight) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (done && !we_q) wb_data_q <= ld_data;
        end
    end

    // Bus qualifiers are forced low outside REQ so an idle bus shows no stale lanes.
    assign mem_we_o    = mem_req_o & we_q;
    assign mem_addr_o  = {addr_q[31:2], 2'b00};
    assign mem_be_o    = mem_req_o ? be : 4'b0000;
    assign mem_wdata_o = mem_req_o ? st_lanes : 32'h0;
    assign wb_rd_o     = rd_q;
    assign wb_data_o   = wb_data_q;
    assign misalign_o  = misalign_q;
    assign bus_err_o   = bus_err_q;
    assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed self-checking bench for lsu_ctrl
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_is_store, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        wb_valid, misalign, bus_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, err_addr;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_is_store_i (req_is_store),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .req_rd_i       (req_rd),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_be_o       (mem_be),
        .mem_wdata_o    (mem_wdata),
        .mem_gnt_i      (mem_gnt),
        .mem_rvalid_i   (mem_rvalid),
        .mem_rdata_i    (mem_rdata),
        .wb_valid_o     (wb_valid),
        .wb_rd_o        (wb_rd),
        .wb_data_o      (wb_data),
        .misalign_o     (misalign),
        .bus_err_o      (bus_err),
        .err_addr_o     (err_addr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        req_valid    = 1'b1;
        req_is_store = st;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        req_rd       = rd;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ready"},    req_ready, 1);
        chk({tag, ".mem_req"},  mem_req,   0);
        chk({tag, ".mem_we"},   mem_we,    0);
        chk({tag, ".mem_addr"}, mem_addr,  0);
        chk({tag, ".mem_be"},   mem_be,    0);
        chk({tag, ".mem_wdat"}, mem_wdata, 0);
        chk({tag, ".wb_valid"}, wb_valid,  0);
        chk({tag, ".wb_rd"},    wb_rd,     0);
        chk({tag, ".wb_data"},  wb_data,   0);
        chk({tag, ".misalign"}, misalign,  0);
        chk({tag, ".bus_err"},  bus_err,   0);
        chk({tag, ".err_addr"}, err_addr,  0);
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 0; req_is_store = 0; req_size = 0; req_unsigned = 0;
        req_addr = 0; req_wdata = 0; req_rd = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b1;
        tick();

        // lbu x8, 0x1003 : grant in REQ, response in WAIT, writeback 3 cycles after accept
        issue(0, 2'b00, 1, 32'h0000_1003, 0, 5'd8);
        chk("lbu.req",   mem_req,  1);
        chk("lbu.ready", req_ready, 0);
        chk("lbu.we",    mem_we,   0);
        chk("lbu.addr",  mem_addr, 32'h0000_1000);
        chk("lbu.be",    mem_be,   4'b1000);
        mem_gnt = 1;
        tick();
        mem_gnt = 0;
        chk("lbu.wait_req", mem_req, 0);
        chk("lbu.wait_wb",  wb_valid, 0);
        mem_rvalid = 1; mem_rdata = 32'h80AB_CDEF;
        tick();
        mem_rvalid = 0;
        chk("lbu.wb_valid", wb_valid, 1);
        chk("lbu.wb_rd",    wb_rd,    8);
        chk("lbu.wb_data",  wb_data,  32'h0000_0080);
        tick();
        chk("lbu.done_wb",    wb_valid,  0);
        chk("lbu.done_ready", req_ready, 1);

        // lh x5, 0x2002 : grant held off one cycle, request must stay stable
        issue(0, 2'b01, 0, 32'h0000_2002, 0, 5'd5);
        chk("lh.be0", mem_be, 4'b1100);
        tick();
        chk("lh.req1",  mem_req,  1);
        chk("lh.be1",   mem_be,   4'b1100);
        chk("lh.addr1", mem_addr, 32'h0000_2000);
        mem_gnt = 1;
        tick();
        mem_gnt = 0;
        mem_rvalid = 1; mem_rdata = 32'h8001_1234;
        tick();
        mem_rvalid = 0;
        chk("lh.wb_valid", wb_valid, 1);
        chk("lh.wb_data",  wb_data,  32'hFFFF_8001);
        tick();

        // sb 0x11 : replicated byte lanes, no writeback
        issue(1, 2'b00, 0, 32'h0000_0011, 32'h1234_56A5, 5'd0);
        chk("sb.we",    mem_we,    1);
        chk("sb.addr",  mem_addr,  32'h0000_0010);
        chk("sb.be",    mem_be,    4'b0010);
        chk("sb.wdata", mem_wdata, 32'hA5A5_A5A5);
        mem_gnt = 1;
        tick();
        mem_gnt = 0;
        mem_rvalid = 1;
        tick();
        mem_rvalid = 0;
        chk("sb.wb",    wb_valid,  0);
        chk("sb.ready", req_ready, 1);

        // sh 0x22 : halfword lanes in the upper half
        issue(1, 2'b01, 0, 32'h0000_0022, 32'h0000_BEEF, 5'd0);
        chk("sh.be",    mem_be,    4'b1100);
        chk("sh.wdata", mem_wdata, 32'hBEEF_BEEF);
        mem_gnt = 1; mem_rvalid = 1;
        tick();
        mem_gnt = 0; mem_rvalid = 0;
        chk("sh.ready", req_ready, 1);
        chk("sh.wb",    wb_valid,  0);

        // lw x3, 0x40 with the unsigned flag set: flag ignored, gnt+rvalid together
        issue(0, 2'b10, 1, 32'h0000_0040, 0, 5'd3);
        chk("lw.be", mem_be, 4'b1111);
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_gnt = 0; mem_rvalid = 0;
        chk("lw.wb_valid", wb_valid, 1);
        chk("lw.wb_rd",    wb_rd,    3);
        chk("lw.wb_data",  wb_data,  32'hDEAD_BEEF);
        tick();

        // misaligned lw at 0x06, then illegal size at 0x0C
        issue(0, 2'b10, 0, 32'h0000_0006, 0, 5'd1);
        chk("mis.pulse", misalign,  1);
        chk("mis.addr",  err_addr,  32'h0000_0006);
        chk("mis.req",   mem_req,   0);
        chk("mis.ready", req_ready, 1);
        tick();
        chk("mis.pulse_end", misalign, 0);
        chk("mis.req2",      mem_req,  0);
        issue(0, 2'b11, 0, 32'h0000_000C, 0, 5'd1);
        chk("ill.pulse", misalign, 1);
        chk("ill.addr",  err_addr, 32'h0000_000C);
        chk("ill.req",   mem_req,  0);
        tick();
        chk("ill.pulse_end", misalign, 0);

        // timeout with no grant: bus error 4 cycles after entering REQ
        issue(0, 2'b10, 0, 32'h0000_0100, 0, 5'd7);
        for (int i = 0; i < 3; i++) begin
            chk("to.req",     mem_req, 1);
            chk("to.no_err",  bus_err, 0);
            tick();
        end
        chk("to.req_last", mem_req, 1);
        tick();
        chk("to.err",      bus_err,   1);
        chk("to.err_addr", err_addr,  32'h0000_0100);
        chk("to.req_drop", mem_req,   0);
        chk("to.ready",    req_ready, 1);
        chk("to.wb",       wb_valid,  0);
        tick();
        chk("to.err_end", bus_err,  0);
        chk("to.wb_end",  wb_valid, 0);

        // lhu x9, 0x0A: response lands on the timeout cycle and must win
        issue(0, 2'b01, 1, 32'h0000_000A, 0, 5'd9);
        mem_gnt = 1;
        tick();
        mem_gnt = 0;
        tick();
        tick();
        mem_rvalid = 1; mem_rdata = 32'h8001_FFFF;
        tick();
        mem_rvalid = 0;
        chk("race.no_err",  bus_err,  0);
        chk("race.wb",      wb_valid, 1);
        chk("race.wb_data", wb_data,  32'h0000_8001);
        tick();

        // load to x0 with same-cycle gnt+rvalid: RESP visited, no writeback
        issue(0, 2'b10, 0, 32'h0000_0200, 0, 5'd0);
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h1111_2222;
        tick();
        mem_gnt = 0; mem_rvalid = 0;
        chk("x0.wb",    wb_valid,  0);
        chk("x0.ready", req_ready, 0);
        tick();
        chk("x0.ready_back", req_ready, 1);

        // reset while waiting for a response abandons the access
        issue(0, 2'b10, 0, 32'h0000_0300, 0, 5'd4);
        mem_gnt = 1;
        tick();
        mem_gnt = 0;
        rst = 1'b0;
        tick();
        chk_all_zero("rst_wait");
        rst = 1'b1;
        mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_rvalid = 0;
        chk("idle_rvalid.wb",    wb_valid,  0);
        chk("idle_rvalid.ready", req_ready, 1);
        tick();
        chk("idle_rvalid.wb2", wb_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store unit controller sitting between decode/execute and the data-memory port. It accepts one decoded load or store at a time and performs the memory request/grant/response handshake. It generates byte enables and lane-replicated write data, then sign- or zero-extends load data and issues a single-cycle register writeback. Misaligned accesses and memory timeouts are detected and reported instead of being issued.

Parameters:
TIMEOUT, 255, cycles waited in REQ+WAIT before a bus error is declared (must be ≥1)

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-low reset
req_valid_i  in  1  load/store request valid
req_ready_o  out  1  controller idle and able to accept
req_is_store_i  in  1  1=store, 0=load
req_size_i  in  2  riscv::mem_size_t: BYTE=00, HWORD=01, WORD=10; 11 illegal
req_unsigned_i  in  1  riscv::sign_t: 1=UNSIGNED load (lbu/lhu)
req_addr_i  in  32  effective byte address (rs1+imm)
req_wdata_i  in  32  store data (rs2), value in low bits
req_rd_i  in  5  load destination register
mem_req_o  out  1  memory request
mem_we_o  out  1  write enable
mem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
mem_be_o  out  4  byte enables
mem_wdata_o  out  32  lane-replicated store data
mem_gnt_i  in  1  request accepted by memory
mem_rvalid_i  in  1  response/ack valid (loads and stores)
mem_rdata_i  in  32  read data, valid with mem_rvalid_i
wb_valid_o  out  1  one-cycle writeback pulse
wb_rd_o  out  5  writeback register
wb_data_o  out  32  extended load result
misalign_o  out  1  one-cycle pulse: misaligned or illegal-size request rejected
bus_err_o  out  1  one-cycle pulse: timeout
err_addr_o  out  32  offending address, held until next error

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, timeout counter=0, all outputs 0 except req_ready_o=1. Reset mid-transaction abandons it: no writeback, no error pulse.
- States (riscv::lsu_state_t): IDLE, REQ, WAIT, RESP.
- req_ready_o = (state==IDLE). A request is accepted when req_valid_i && req_ready_o. Fields are captured into registers; the outputs driven to memory come from those registers.
- Alignment check at acceptance:
  - HWORD needs addr[0]=0; WORD needs addr[1:0]=0; size 11 is always illegal.
  - On failure: next cycle misalign_o=1 and err_addr_o=addr, state stays IDLE, no memory access.
- IDLE -> REQ on an aligned acceptance (1-cycle latency to mem_req_o).
- REQ: mem_req_o=1; addr/we/be/wdata stable until grant.
  - mem_gnt_i without mem_rvalid_i -> WAIT.
  - mem_gnt_i with mem_rvalid_i in the same cycle -> treated as a completed response.
- WAIT: mem_req_o=0. mem_rvalid_i completes the access.
- Completion:
  - Store -> IDLE, no writeback.
  - Load -> RESP with extended data registered.
- RESP: wb_valid_o=1 for exactly one cycle, then -> IDLE. wb_valid_o is suppressed when rd=0; the state still passes through RESP.
- Load-to-writeback latency with immediate grant and rvalid the cycle after grant: accept (cycle 0), REQ (1), WAIT (2, rvalid), RESP (3, wb_valid_o).
- mem_rvalid_i seen in IDLE or RESP is ignored.
- Timeout:
  - The counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - When it reaches TIMEOUT: bus_err_o pulses, err_addr_o=addr, -> IDLE, no writeback.
  - A completion in the same cycle as the timeout wins; no error is raised.
- Byte enables:
  - BYTE: 4'b0001<<addr[1:0].
  - HWORD: 4'b0011<<{addr[1],1'b0}.
  - WORD: 4'b1111.
- Store data lanes: BYTE replicates wdata[7:0] ×4; HWORD replicates wdata[15:0] ×2; WORD passes through.
- Load data: rdata>>(addr[1:0]*8), then take 8/16/32 bits. Sign-extend unless req_unsigned_i; a WORD load ignores req_unsigned_i.

Decomposition:
- riscv package: mem_size_t and sign_t (existing BYTE/HWORD/WORD, SIGNED/UNSIGNED), lsu_state_t enum, functions lsu_be(size,addr) and lsu_misaligned(size,addr).
- One combinational sub-module, lsu_align: byte-enable generation, store lane replication, load shift and extension. It is shared by RTL and reusable by the bench's reference model.

Test Plan:
- lbu, addr=0x0000_1003, rdata=0x80AB_CDEF, rd=x8 -> mem_addr_o=0x0000_1000, mem_be_o=4'b1000; 3 cycles after acceptance wb_valid_o=1, wb_rd_o=8, wb_data_o=0x0000_0080.
- lh (SIGNED), addr=0x2002, rdata=0x8001_1234 -> mem_be_o=4'b1100, wb_data_o=0xFFFF_8001.
- sb, addr=0x11, wdata=0x1234_56A5 -> mem_we_o=1, mem_be_o=4'b0010, mem_wdata_o=0xA5A5_A5A5; no wb_valid_o after rvalid; req_ready_o returns to 1.
- lw at addr=0x06 -> misalign_o pulses one cycle later, err_addr_o=0x06, mem_req_o never asserted; same result for size=11.
- TIMEOUT=4, mem_gnt_i held 0 -> bus_err_o pulses 4 cycles after entering REQ, mem_req_o drops, no writeback.
- Load with rd=x0 and gnt+rvalid in the same cycle -> completes via RESP with wb_valid_o=0. Then assert rst=0 while in WAIT on a new load -> next cycle IDLE, all outputs 0, no wb pulse.
